// File: rtl/xpb_seg_accumulator.sv
// rtl/xpb_seg_accumulator.sv - serial XPB segment reduction onto the low part of a square result
// XPB_SEG_ZERO_SKIP_EN: skip zero-valued segments instead of issuing them
module xpb_seg_accumulator #(
  parameter int LOW_W   = 1024,
  parameter int SEG_W   = 5,
  parameter int NUM_SEG = 8,
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 1028
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LOW_W+NUM_SEG*SEG_W-1:0] in_data,
  output logic [SEL_W-1:0]               lut_sel,
  output logic [SEG_W-1:0]               lut_idx,
  output logic                           lut_en,
  input  logic [LOW_W-1:0]               lut_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data
);

  localparam int UP_W = NUM_SEG * SEG_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [OUT_W-1:0] acc;
  logic [UP_W-1:0]  seg_reg;
  logic [SEL_W-1:0] seg_cnt;
  logic             pend;
  logic [SEL_W-1:0] cur_sel;
  logic             last_seg;
  logic [UP_W-1:0]  upper;

  assign upper = in_data[LOW_W +: UP_W];

`ifdef XPB_SEG_ZERO_SKIP_EN
  logic found;

  // First nonzero segment at or after seg_cnt; last_seg when no other nonzero follows it.
  always_comb begin
    cur_sel  = seg_cnt;
    last_seg = 1'b1;
    found    = 1'b0;
    for (int j = 0; j < NUM_SEG; j++) begin
      if (j >= int'(seg_cnt) && seg_reg[j*SEG_W +: SEG_W] != '0) begin
        if (!found) begin
          found   = 1'b1;
          cur_sel = SEL_W'(j);
        end else begin
          last_seg = 1'b0;
        end
      end
    end
  end
`else
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_SEG - 1);

  always_comb begin
    cur_sel  = seg_cnt;
    last_seg = (seg_cnt == LAST);
  end
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign lut_en    = (state == ISSUE);
  assign lut_sel   = lut_en ? cur_sel : '0;
  assign lut_idx   = lut_en ? seg_reg[cur_sel*SEG_W +: SEG_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      seg_reg <= '0;
      seg_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            seg_reg <= upper;
            acc     <= OUT_W'(in_data[LOW_W-1:0]);
            seg_cnt <= '0;
            pend    <= 1'b0;
`ifdef XPB_SEG_ZERO_SKIP_EN
            state   <= (upper == '0) ? DONE : ISSUE;
`else
            state   <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // lut_data arriving now belongs to the lookup issued on the previous cycle
          if (pend) acc <= acc + OUT_W'(lut_data);
          pend    <= 1'b1;
          seg_cnt <= cur_sel + 1'b1;
          if (last_seg) state <= DRAIN;
        end
        DRAIN: begin
          acc   <= acc + OUT_W'(lut_data);
          pend  <= 1'b0;
          state <= DONE;
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule
